// File: rtl/seg7_display_mux_4.sv
// Time-multiplexed 4-digit seven-segment scanner: per-frame BCD snapshot, one blank cycle per slot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_display_mux_4 #(
  parameter int CLK_DIVIDER        = 50000,
  parameter int SEGMENT_ACTIVE_LOW = 1,
  parameter int ANODE_ACTIVE_LOW   = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [0:3] Digit3,
  input  logic [0:3] Digit2,
  input  logic [0:3] Digit1,
  input  logic [0:3] Digit0,
  output logic [6:0] Segments,
  output logic [3:0] Anodes,
  output logic       FrameStart
);

  localparam int PW = (CLK_DIVIDER > 2) ? $clog2(CLK_DIVIDER) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLK_DIVIDER - 1);
  localparam logic [6:0]    SEG_OFF = (SEGMENT_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]    AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  // Active-high {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [PW-1:0] prescale_q, prescale_d;
  logic [1:0]    index_q, index_d;
  logic [15:0]   snap_q, snap_d;
  logic          frame_start_q, frame_start_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic          frame_wrap;
  logic [3:0]    cur_digit;
  logic          blank_digit;
  logic [6:0]    seg_on;
  logic [3:0]    an_on;

  always_comb begin
    tick       = Enable && (prescale_q == PRESCALE_MAX);
    frame_wrap = tick && (index_q == 2'd3);

    prescale_d = prescale_q;
    if (Enable) begin
      prescale_d = tick ? '0 : prescale_q + PW'(1);
    end

    index_d       = tick ? index_q + 2'd1 : index_q;
    snap_d        = frame_wrap ? {Digit3, Digit2, Digit1, Digit0} : snap_q;
    frame_start_d = frame_wrap;
  end

  always_comb begin
    case (index_q)
      2'd0:    cur_digit = snap_q[3:0];
      2'd1:    cur_digit = snap_q[7:4];
      2'd2:    cur_digit = snap_q[11:8];
      default: cur_digit = snap_q[15:12];
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank only when it and every more-significant digit are zero.
    case (index_q)
      2'd3:    blank_digit = (snap_q[15:12] == 4'd0);
      2'd2:    blank_digit = (snap_q[15:8] == 8'd0);
      2'd1:    blank_digit = (snap_q[15:4] == 12'd0);
      default: blank_digit = 1'b0;
    endcase
`else
    blank_digit = 1'b0;
`endif

    seg_on = blank_digit ? 7'h00 : seg7_decode(cur_digit);
    an_on  = 4'b0001 << index_q;
  end

  // Blank the display for the cycle after each tick and whenever scanning is paused.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (Enable && !tick) begin
      seg_d = (SEGMENT_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
      an_d  = (ANODE_ACTIVE_LOW != 0) ? ~an_on : an_on;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescale_q    <= '0;
      index_q       <= 2'd3;
      snap_q        <= '0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
    end else begin
      prescale_q    <= prescale_d;
      index_q       <= index_d;
      snap_q        <= snap_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign Segments   = seg_q;
  assign Anodes     = an_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_seg7_display_mux_4.sv
// Directed bench for seg7_display_mux_4 with CLK_DIVIDER=4 and default polarities.
// Edge numbers count rising clock edges after Reset is released.
module tb_seg7_display_mux_4;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z_LEAD = 7'h7F;
`else
  localparam logic [6:0] Z_LEAD = 7'h40;
`endif

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] d3, d2, d1, d0;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  seg7_display_mux_4 #(
    .CLK_DIVIDER       (DIV),
    .SEGMENT_ACTIVE_LOW(1),
    .ANODE_ACTIVE_LOW  (1)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Enable    (enable),
    .Digit3    (d3),
    .Digit2    (d2),
    .Digit1    (d1),
    .Digit0    (d0),
    .Segments  (segments),
    .Anodes    (anodes),
    .FrameStart(frame_start)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                           input logic fs);
    check({tag, ".an"}, 32'(anodes), 32'(an));
    check({tag, ".seg"}, 32'(segments), 32'(seg));
    check({tag, ".fs"}, 32'(frame_start), 32'(fs));
  endtask

  // Advance to 1 time unit after the given rising edge.
  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    set_digits(4'd0, 4'd1, 4'd4, 4'd2);

    // Held in reset
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", 4'hF, 7'h7F, 1'b0);
    reset = 1'b0;
    edge_n = 0;

    // Value 142: first frame after reset
    step_to(3);
    check("pre_tick.fs", 32'(frame_start), 32'd0);
    step_to(4);
    check_out("tick4_blank", 4'hF, 7'h7F, 1'b1);
    step_to(5);
    check_out("d0_142", 4'b1110, 7'h24, 1'b0);
    step_to(7);
    check_out("d0_142_last", 4'b1110, 7'h24, 1'b0);
    step_to(8);
    check_out("slot1_blank", 4'hF, 7'h7F, 1'b0);
    step_to(9);
    check_out("d1_142", 4'b1101, 7'h19, 1'b0);
    step_to(13);
    check_out("d2_142", 4'b1011, 7'h79, 1'b0);
    step_to(17);
    check_out("d3_142", 4'b0111, Z_LEAD, 1'b0);

    // 599 captured at edge 20, then inputs change to 89 mid digit-1 slot
    set_digits(4'd0, 4'd5, 4'd9, 4'd9);
    step_to(20);
    check_out("frame2_start", 4'hF, 7'h7F, 1'b1);
    step_to(21);
    check_out("d0_599", 4'b1110, 7'h10, 1'b0);
    step_to(25);
    check_out("d1_599", 4'b1101, 7'h10, 1'b0);
    set_digits(4'd0, 4'd0, 4'd8, 4'd9);
    step_to(26);
    check_out("d1_599_held", 4'b1101, 7'h10, 1'b0);
    step_to(29);
    check_out("d2_599_held", 4'b1011, 7'h12, 1'b0);
    step_to(33);
    check_out("d3_599_held", 4'b0111, Z_LEAD, 1'b0);
    step_to(36);
    check_out("frame3_start", 4'hF, 7'h7F, 1'b1);
    step_to(37);
    check_out("d0_89", 4'b1110, 7'h10, 1'b0);
    step_to(41);
    check_out("d1_89", 4'b1101, 7'h00, 1'b0);
    step_to(45);
    check_out("d2_89", 4'b1011, Z_LEAD, 1'b0);
    step_to(49);
    check_out("d3_89", 4'b0111, Z_LEAD, 1'b0);

    // Non-BCD units digit
    set_digits(4'd0, 4'd0, 4'd8, 4'hB);
    step_to(52);
    check_out("frame4_start", 4'hF, 7'h7F, 1'b1);
    step_to(53);
    check_out("d0_dash", 4'b1110, 7'h3F, 1'b0);
    step_to(57);
    check_out("d1_8", 4'b1101, 7'h00, 1'b0);

    // Pause for 10 cycles in the middle of the digit-1 slot
    enable = 1'b0;
    step_to(58);
    check_out("pause_first", 4'hF, 7'h7F, 1'b0);
    step_to(67);
    check_out("pause_last", 4'hF, 7'h7F, 1'b0);
    enable = 1'b1;
    step_to(68);
    check_out("resume_d1", 4'b1101, 7'h00, 1'b0);
    step_to(69);
    check_out("resume_d1_last", 4'b1101, 7'h00, 1'b0);
    step_to(70);
    check_out("resume_tick_blank", 4'hF, 7'h7F, 1'b0);
    step_to(71);
    check_out("resume_d2", 4'b1011, Z_LEAD, 1'b0);

    // Asynchronous reset in the middle of a drive cycle
    #3;
    reset = 1'b1;
    #1;
    check_out("reset_async", 4'hF, 7'h7F, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_async_hold", 4'hF, 7'h7F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
